// File: rtl/vid_pkg.sv
// Shared types and defaults for the video raster output path.
package vid_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hsync;
        logic hblank;
        logic vsync;
        logic vblank;
        logic frame_start;
        logic underflow;
    } timing_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [23:0] DEF_FILL_RGB = 24'h000000;

    // Blanked raster: both blanks high, syncs and flags low.
    localparam timing_t TIMING_IDLE = '{
        hsync:       1'b0,
        hblank:      1'b1,
        vsync:       1'b0,
        vblank:      1'b1,
        frame_start: 1'b0,
        underflow:   1'b0
    };

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic logic in_window(input logic [31:0] pos, input int lo, input int len);
        return (pos >= 32'(lo)) && (pos < 32'(lo + len));
    endfunction

endpackage

// File: rtl/vid_wrap_counter.sv
// Modulo-MAX position counter; wrap is high on the increment that returns it to zero.
module vid_wrap_counter
    import vid_pkg::*;
#(
    parameter int MAX = 8,
    localparam int W  = cnt_width(MAX)
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = inc && (cnt == W'(MAX - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || wrap) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator and pixel output stage fed from a show-ahead pixel FIFO.
module vid_timing_gen
    import vid_pkg::*;
#(
    parameter int          H_ACTIVE = DEF_H_ACTIVE,
    parameter int          H_FP     = DEF_H_FP,
    parameter int          H_SYNC   = DEF_H_SYNC,
    parameter int          H_BP     = DEF_H_BP,
    parameter int          V_ACTIVE = DEF_V_ACTIVE,
    parameter int          V_FP     = DEF_V_FP,
    parameter int          V_SYNC   = DEF_V_SYNC,
    parameter int          V_BP     = DEF_V_BP,
    parameter logic [23:0] FILL_RGB = DEF_FILL_RGB
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_rd,
    output logic        hsync,
    output logic        hblank,
    output logic        vsync,
    output logic        vblank,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        frame_start,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_wrap;
    logic          v_wrap_unused;
    logic [31:0]   h_pos;
    logic [31:0]   v_pos;
    logic          active;
    rgb_t          rgb_d;
    rgb_t          rgb_q;
    timing_t       tim_q;

    // Disabling clears both counters so re-enable starts exactly at the first active pixel.
    vid_wrap_counter #(.MAX(H_TOTAL)) u_hcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (enable),
        .clr   (~enable),
        .cnt   (hcnt),
        .wrap  (h_wrap)
    );

    vid_wrap_counter #(.MAX(V_TOTAL)) u_vcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (h_wrap),
        .clr   (~enable),
        .cnt   (vcnt),
        .wrap  (v_wrap_unused)
    );

    assign h_pos = 32'(hcnt);
    assign v_pos = 32'(vcnt);

    // Reset gates the pop directly: counters reset to (0,0), which is itself an active position.
    assign active = ~reset & enable & (h_pos < 32'(H_ACTIVE)) & (v_pos < 32'(V_ACTIVE));
    assign pix_rd = active & pix_valid;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rgb_d = '0;
        if (active) begin
            rgb_d = pix_valid ? rgb_t'(pix_data) : rgb_t'(FILL_RGB);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tim_q <= TIMING_IDLE;
            rgb_q <= '0;
        end else if (!enable) begin
            tim_q <= TIMING_IDLE;
            rgb_q <= '0;
        end else begin
            tim_q.hblank      <= h_pos >= 32'(H_ACTIVE);
            tim_q.hsync       <= in_window(h_pos, H_ACTIVE + H_FP, H_SYNC);
            tim_q.vblank      <= v_pos >= 32'(V_ACTIVE);
            tim_q.vsync       <= in_window(v_pos, V_ACTIVE + V_FP, V_SYNC);
            tim_q.frame_start <= active && (hcnt == '0) && (vcnt == '0);
            tim_q.underflow   <= tim_q.underflow | (active & ~pix_valid);
            rgb_q             <= rgb_d;
        end
    end

    assign hsync       = tim_q.hsync;
    assign hblank      = tim_q.hblank;
    assign vsync       = tim_q.vsync;
    assign vblank      = tim_q.vblank;
    assign frame_start = tim_q.frame_start;
    assign underflow   = tim_q.underflow;
    assign R           = rgb_q.r;
    assign G           = rgb_q.g;
    assign B           = rgb_q.b;

endmodule
